// File: rtl/chacha_pkg.sv
// Shared types and constants for the ChaCha block engine.
// Index tables list the (a,b,c,d) word positions of each quarter-round lane.
package chacha_pkg;

    localparam int WIDTH_C = 32;

    localparam logic [WIDTH_C-1:0] SIGMA0 = 32'h61707865;
    localparam logic [WIDTH_C-1:0] SIGMA1 = 32'h3320646e;
    localparam logic [WIDTH_C-1:0] SIGMA2 = 32'h79622d32;
    localparam logic [WIDTH_C-1:0] SIGMA3 = 32'h6b206574;

    // Word i of the block lives at bits [32*i +: 32].
    typedef logic [15:0][WIDTH_C-1:0] state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } fsm_e;

    localparam logic [3:0] COL_IDX [4][4] = '{
        '{4'd0, 4'd4, 4'd8,  4'd12},
        '{4'd1, 4'd5, 4'd9,  4'd13},
        '{4'd2, 4'd6, 4'd10, 4'd14},
        '{4'd3, 4'd7, 4'd11, 4'd15}
    };

    localparam logic [3:0] DIAG_IDX [4][4] = '{
        '{4'd0, 4'd5, 4'd10, 4'd15},
        '{4'd1, 4'd6, 4'd11, 4'd12},
        '{4'd2, 4'd7, 4'd8,  4'd13},
        '{4'd3, 4'd4, 4'd9,  4'd14}
    };

endpackage

// File: rtl/chacha_quarter_round.sv
// ChaCha quarter-round: purely combinational add/xor/rotate chain.
// Latency 0 cycles; no flow control, the caller registers the result.
module chacha_quarter_round #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] c_o,
    output logic [WIDTH-1:0] d_o
);

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input int n);
        return (v << n) | (v >> (WIDTH - n));
    endfunction

    logic [WIDTH-1:0] a1, b1, c1, d1;

    always_comb begin
        a1  = a_i + b_i;
        d1  = rotl(d_i ^ a1, 16);
        c1  = c_i + d1;
        b1  = rotl(b_i ^ c1, 12);
        a_o = a1 + b1;
        d_o = rotl(d1 ^ a_o, 8);
        c_o = c1 + d_o;
        b_o = rotl(b1 ^ c_o, 7);
    end

endmodule

// File: rtl/chacha_block_engine.sv
// Sequential ChaCha block function, one round per clock; CHACHA_XOR_EN adds data_in XOR.
// Latency ROUNDS+1 edges accept-to-out_valid; out_valid/ks_out hold until out_ready, in_ready only in IDLE.
module chacha_block_engine
    import chacha_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ROUNDS = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*WIDTH-1:0]  key,
    input  logic [WIDTH-1:0]    counter,
    input  logic [3*WIDTH-1:0]  nonce,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*WIDTH-1:0] ks_out
`ifdef CHACHA_XOR_EN
    ,
    input  logic [16*WIDTH-1:0] data_in
`endif
);

    localparam int RND_W = $clog2(ROUNDS);

    if (WIDTH != WIDTH_C) begin : g_bad_width
        $error("chacha_block_engine: WIDTH must be 32");
    end
    if (!(ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20)) begin : g_bad_rounds
        $error("chacha_block_engine: ROUNDS must be 8, 12 or 20");
    end

    fsm_e             state_q, state_d;
    logic [RND_W-1:0] rnd_q, rnd_d;
    state_t           st_q, st_d;
    state_t           init_q, init_d;
    state_t           ks_q, ks_d;
    state_t           st_rnd;
    state_t           xor_mask;
    logic             accept;

    logic [3:0][3:0]       ia, ib, ic, id;
    logic [3:0][WIDTH-1:0] qa, qb, qc, qd;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign ks_out    = ks_q;
    assign accept    = in_valid && in_ready;

    // rnd_q[0] picks column (even) or diagonal (odd) lane wiring.
    for (genvar q = 0; q < 4; q++) begin : g_qr
        assign ia[q] = rnd_q[0] ? DIAG_IDX[q][0] : COL_IDX[q][0];
        assign ib[q] = rnd_q[0] ? DIAG_IDX[q][1] : COL_IDX[q][1];
        assign ic[q] = rnd_q[0] ? DIAG_IDX[q][2] : COL_IDX[q][2];
        assign id[q] = rnd_q[0] ? DIAG_IDX[q][3] : COL_IDX[q][3];

        chacha_quarter_round #(.WIDTH(WIDTH)) u_qr (
            .a_i (st_q[ia[q]]),
            .b_i (st_q[ib[q]]),
            .c_i (st_q[ic[q]]),
            .d_i (st_q[id[q]]),
            .a_o (qa[q]),
            .b_o (qb[q]),
            .c_o (qc[q]),
            .d_o (qd[q])
        );
    end

    always_comb begin
        st_rnd = st_q;
        for (int q = 0; q < 4; q++) begin
            st_rnd[ia[q]] = qa[q];
            st_rnd[ib[q]] = qb[q];
            st_rnd[ic[q]] = qc[q];
            st_rnd[id[q]] = qd[q];
        end
    end

`ifdef CHACHA_XOR_EN
    state_t din_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            din_q <= '0;
        end else if (accept) begin
            din_q <= data_in;
        end
    end

    assign xor_mask = din_q;
`else
    assign xor_mask = '0;
`endif

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        st_d    = st_q;
        init_d  = init_q;
        ks_d    = ks_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    st_d    = {nonce, counter, key, SIGMA3, SIGMA2, SIGMA1, SIGMA0};
                    init_d  = {nonce, counter, key, SIGMA3, SIGMA2, SIGMA1, SIGMA0};
                    rnd_d   = '0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                st_d  = st_rnd;
                rnd_d = rnd_q + 1'b1;
                if (rnd_q == RND_W'(ROUNDS - 1)) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                // Per-word modular add; carries never cross word boundaries.
                for (int i = 0; i < 16; i++) begin
                    ks_d[i] = (st_q[i] + init_q[i]) ^ xor_mask[i];
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            st_q    <= '0;
            init_q  <= '0;
            ks_q    <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            st_q    <= st_d;
            init_q  <= init_d;
            ks_q    <= ks_d;
        end
    end

endmodule
